iob_timer_alarm_ctrl: RTL and testbench
=======================================

# iob_timer_alarm_ctrl

Multi-channel alarm scheduler for the free-running 64-bit timer counter. It holds N_CH programmable deadlines and scans them round-robin through one shared wrap-safe comparator. When a deadline is reached it raises a per-channel pending flag and a combined interrupt, and either disarms the channel or reloads it with a period. It sits beside the timer core and takes the core's counter value as input; software configures it through a single-cycle command port driven by the register file.

## Interface
- N_CH, 4: number of alarm channels (power of two, 2–16)
- TIMER_W, 64: width of timer value, deadlines and periods
- CH_W, $clog2(N_CH): channel index width (derived)
- clk_i  in  1  system clock
- arst_n_i  in  1  reset, asynchronous and active-low
- cke_i  in  1  clock enable; when low, all state holds
- timer_value_i  in  TIMER_W  current counter value from the timer core
- cfg_valid_i  in  1  command request
- cfg_ready_o  out  1  command accepted when valid and ready are both high
- cfg_op_i  in  2  command: 0 NOP, 1 ARM, 2 DISARM, 3 ACK
- cfg_ch_i  in  CH_W  target channel
- cfg_deadline_i  in  TIMER_W  absolute deadline (ARM only)
- cfg_period_i  in  TIMER_W  reload period; 0 means one-shot (ARM only)
- armed_o  out  N_CH  per-channel armed flags
- pending_o  out  N_CH  per-channel fired-not-acknowledged flags
- irq_o  out  1  OR of pending_o
- scan_ch_o  out  CH_W  channel being compared this cycle (debug)

## Operation
- FSM states:
  - CLEAR: entered on reset. Writes deadline=0, period=0, armed=0 and pending=0 to one channel per cycle (index 0..N_CH-1), then moves to SCAN. cfg_ready_o is 0.
  - SCAN: cfg_ready_o = cke_i. A scan pointer advances by 1 per enabled cycle and wraps from N_CH-1 to 0.
- Reached test: the channel at the scan pointer counts as reached when armed and the MSB of (timer_value_i − deadline) mod 2^TIMER_W is 0. This makes the compare wrap-safe over half the counter range.
- On a reached channel:
  - pending is set.
  - If period ≠ 0: deadline ← deadline + period (mod 2^TIMER_W) and the channel stays armed.
  - Otherwise the channel is cleared from armed.
  - Only one reload happens per visit, so a deadline left in the past catches up by one period per scan round.
- ARM: writes deadline and period, sets armed, clears pending.
- DISARM: clears armed; pending is unchanged.
- ACK: clears pending.
- NOP: no effect.
- Command on the channel being scanned in the same cycle: the command wins and the scan result for that channel is discarded for this visit.
- ACK arriving in the same cycle a different fire sets pending on another channel: both take effect.
- Reset asserted mid-operation: all state clears asynchronously and CLEAR restarts.

## Timing
- Reset values:
  - cfg_ready_o=0, armed_o=0, pending_o=0, irq_o=0, scan_ch_o=0; FSM in CLEAR.
  - cfg_ready_o first rises N_CH enabled cycles after reset release.
- Commands take effect on the clock edge of acceptance; armed_o and pending_o show the new value the following cycle.
- Fire latency: pending_o rises on the edge that closes the cycle in which the channel is scanned and reached. Worst case is N_CH cycles after timer_value_i first reaches the deadline. irq_o is combinational from pending_o, so it rises in the same cycle.
- cke_i low: the scan pointer, FSM and all flags hold, and no command is accepted.

## Configuration
- Macro IOB_TIMER_ALARM_PERIODIC_EN.
- Defined: period storage and the reload adder are present, with behaviour as above.
- Undefined:
  - no period storage and no adder;
  - cfg_period_i is ignored;
  - every fire disarms the channel (one-shot only).

## Structure
- Package iob_timer_alarm_pkg holds:
  - op encodings OP_NOP, OP_ARM, OP_DISARM, OP_ACK;
  - the FSM state type (CLEAR, SCAN).
- Sub-module iob_timer_alarm_cmp: purely combinational wrap-safe compare plus reload adder, instanced once and shared by the scanned channel.
- Deadline and period storage are register arrays indexed by the scan pointer and by cfg_ch_i.

## Test plan
- Reset release with cke_i=1 → cfg_ready_o=0 for 4 cycles, then 1; armed_o=0, pending_o=0.
- ARM ch2 with deadline=100, period=0, timer ramping from 90 → pending_o[2] rises within 4 cycles after timer=100; armed_o[2]=0; ACK ch2 → pending_o=0 and irq_o=0.
- ARM ch1 with deadline=50, period=20 (macro defined) → fires near 50, 70 and 90, with the stored deadline advancing by 20 each fire; with the macro undefined, a single fire only.
- Wrap: ARM with deadline=0x0000_0000_0000_0005 while timer=0xFFFF_FFFF_FFFF_FFF0 → no fire until the timer wraps to ≥5, then it fires.
- Command collision: DISARM ch0 in the cycle ch0 is scanned and reached → pending_o[0] stays 0 and armed_o[0]=0.
- Hold cke_i=0 for 10 cycles with a channel due → scan_ch_o frozen, no fire; fires within 4 cycles of cke_i returning to 1.

Source files
------------

// File: rtl/iob_timer_alarm_pkg.sv
// Shared encodings for the timer alarm scheduler: command opcodes and FSM states.
package iob_timer_alarm_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_ARM    = 2'd1,
    OP_DISARM = 2'd2,
    OP_ACK    = 2'd3
  } op_e;

  typedef enum logic {
    CLEAR = 1'b0,
    SCAN  = 1'b1
  } state_e;

endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// Shared wrap-safe deadline compare and period reload adder for the scanned channel.
// IOB_TIMER_ALARM_PERIODIC_EN adds the period input and the reload adder.
module iob_timer_alarm_cmp #(
  parameter int TIMER_W = 64
) (
  input  logic               armed,
  input  logic [TIMER_W-1:0] timer_value,
  input  logic [TIMER_W-1:0] deadline,
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
  input  logic [TIMER_W-1:0] period,
`endif
  output logic               reached,
  output logic               reload,
  output logic [TIMER_W-1:0] next_deadline
);

  // Sign of the modular difference: reached while within half the range past the deadline.
  assign reached = armed &&
                   ($signed(timer_value - deadline) >= $signed({TIMER_W{1'b0}}));

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
  assign reload        = (period != '0);
  assign next_deadline = deadline + period;
`else
  assign reload        = 1'b0;
  assign next_deadline = deadline;
`endif

endmodule

// File: rtl/iob_timer_alarm_ctrl.sv
// Multi-channel alarm scheduler: round-robin scan of N_CH deadlines through one comparator.
// IOB_TIMER_ALARM_PERIODIC_EN enables per-channel period storage and auto-reload.
module iob_timer_alarm_ctrl
  import iob_timer_alarm_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int TIMER_W = 64,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic [TIMER_W-1:0] timer_value_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_op_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [TIMER_W-1:0] cfg_deadline_i,
  input  logic [TIMER_W-1:0] cfg_period_i,
  output logic [N_CH-1:0]    armed_o,
  output logic [N_CH-1:0]    pending_o,
  output logic               irq_o,
  output logic [CH_W-1:0]    scan_ch_o
);

  state_e                         state_q, state_d;
  logic [CH_W-1:0]                ptr_q;
  logic [N_CH-1:0][TIMER_W-1:0]   deadline_q;
  logic [N_CH-1:0]                armed_q, pending_q;
  logic                           reached, reload, accept, collide, fire;
  logic [TIMER_W-1:0]             next_deadline;

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
  logic [N_CH-1:0][TIMER_W-1:0]   period_q;
`else
  logic                           unused_period;
  assign unused_period = ^cfg_period_i;
`endif

  iob_timer_alarm_cmp #(.TIMER_W(TIMER_W)) u_cmp (
    .armed         (armed_q[ptr_q]),
    .timer_value   (timer_value_i),
    .deadline      (deadline_q[ptr_q]),
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    .period        (period_q[ptr_q]),
`endif
    .reached       (reached),
    .reload        (reload),
    .next_deadline (next_deadline)
  );

  assign accept  = cfg_valid_i && cfg_ready_o;
  // A real command on the scanned channel overrides this visit's compare result.
  assign collide = accept && (cfg_op_i != OP_NOP) && (cfg_ch_i == ptr_q);
  assign fire    = (state_q == SCAN) && reached && !collide;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= CLEAR;
    else if (cke_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && ptr_q == CH_W'(N_CH - 1)) state_d = SCAN;
  end

  always_comb begin
    cfg_ready_o = 1'b0;
    if (state_q == SCAN) cfg_ready_o = cke_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ptr_q      <= '0;
      deadline_q <= '0;
      armed_q    <= '0;
      pending_q  <= '0;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
      period_q   <= '0;
`endif
    end else if (cke_i) begin
      ptr_q <= ptr_q + CH_W'(1);
      if (state_q == CLEAR) begin
        deadline_q[ptr_q] <= '0;
        armed_q[ptr_q]    <= 1'b0;
        pending_q[ptr_q]  <= 1'b0;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        period_q[ptr_q]   <= '0;
`endif
      end else begin
        if (fire) begin
          pending_q[ptr_q] <= 1'b1;
          if (reload) deadline_q[ptr_q] <= next_deadline;
          else        armed_q[ptr_q]    <= 1'b0;
        end
        if (accept) begin
          case (cfg_op_i)
            OP_ARM: begin
              deadline_q[cfg_ch_i] <= cfg_deadline_i;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
              period_q[cfg_ch_i]   <= cfg_period_i;
`endif
              armed_q[cfg_ch_i]    <= 1'b1;
              pending_q[cfg_ch_i]  <= 1'b0;
            end
            OP_DISARM: armed_q[cfg_ch_i]   <= 1'b0;
            OP_ACK:    pending_q[cfg_ch_i] <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  assign armed_o   = armed_q;
  assign pending_o = pending_q;
  assign irq_o     = |pending_q;
  assign scan_ch_o = ptr_q;

endmodule

// File: tb/tb_iob_timer_alarm_ctrl.sv
// Directed bench for iob_timer_alarm_ctrl; covers one-shot, periodic (IOB_TIMER_ALARM_PERIODIC_EN), wrap, collision, clock-enable and reset.
module tb_iob_timer_alarm_ctrl;
  import iob_timer_alarm_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 64;

  logic          clk = 1'b0;
  logic          arst_n, cke, cfg_valid, cfg_ready, irq;
  logic [W-1:0]  timer, cfg_deadline, cfg_period;
  logic [1:0]    cfg_op, cfg_ch, scan_ch;
  logic [N_CH-1:0] armed, pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iob_timer_alarm_ctrl #(.N_CH(N_CH), .TIMER_W(W)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .cke_i          (cke),
    .timer_value_i  (timer),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_op_i       (cfg_op),
    .cfg_ch_i       (cfg_ch),
    .cfg_deadline_i (cfg_deadline),
    .cfg_period_i   (cfg_period),
    .armed_o        (armed),
    .pending_o      (pending),
    .irq_o          (irq),
    .scan_ch_o      (scan_ch)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmd(input logic [1:0] op, input int ch, input logic [W-1:0] dl, input logic [W-1:0] pr);
    logic [31:0] chv;
    chv          = ch;
    cfg_valid    = 1'b1;
    cfg_op       = op;
    cfg_ch       = chv[1:0];
    cfg_deadline = dl;
    cfg_period   = pr;
    tick();
    cfg_valid    = 1'b0;
    cfg_op       = OP_NOP;
  endtask

  // Up to max edges waiting for a channel's pending flag.
  task automatic wait_pend(input int ch, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (pending[ch]) break;
    end
  endtask

  task automatic wait_scan(input logic [1:0] ch);
    for (int i = 0; i < 8; i++) begin
      if (scan_ch == ch) break;
      tick();
    end
    check("scan_sync", {62'd0, scan_ch}, {62'd0, ch});
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; timer = '0;
    cfg_valid = 1'b0; cfg_op = OP_NOP; cfg_ch = '0; cfg_deadline = '0; cfg_period = '0;
    ticks(2);
    check("rst_ready",   cfg_ready, 0);
    check("rst_armed",   armed,     0);
    check("rst_pending", pending,   0);
    check("rst_irq",     irq,       0);
    check("rst_scan",    scan_ch,   0);
    arst_n = 1'b1;
    for (int i = 1; i < N_CH; i++) begin
      tick();
      check("clear_ready", cfg_ready, 0);
    end
    tick();
    check("scan_ready", cfg_ready, 1);
    check("scan_start", scan_ch,   0);

    // One-shot on ch2
    timer = 90;
    cmd(OP_ARM, 2, 100, 0);
    check("arm2_armed", armed, 4'b0100);
    ticks(8);
    check("arm2_early", pending, 0);
    timer = 100;
    wait_pend(2, 4);
    check("os_pend",  pending, 4'b0100);
    check("os_armed", armed,   0);
    check("os_irq",   irq,     1);
    cmd(OP_ACK, 2, 0, 0);
    check("ack2_pend", pending, 0);
    check("ack2_irq",  irq,     0);

    // Periodic on ch1
    timer = 40;
    cmd(OP_ARM, 1, 50, 20);
    check("arm1_armed", armed, 4'b0010);
    timer = 50;
    wait_pend(1, 4);
    check("p50_pend", pending, 4'b0010);
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    check("p50_armed", armed, 4'b0010);
    cmd(OP_ACK, 1, 0, 0);
    timer = 69;
    ticks(8);
    check("p69_quiet", pending, 0);
    timer = 70;
    wait_pend(1, 4);
    check("p70_pend", pending, 4'b0010);
    cmd(OP_ACK, 1, 0, 0);
    timer = 89;
    ticks(8);
    check("p89_quiet", pending, 0);
    timer = 90;
    wait_pend(1, 4);
    check("p90_pend", pending, 4'b0010);
    cmd(OP_ACK, 1, 0, 0);
    cmd(OP_DISARM, 1, 0, 0);
    check("p_disarm", armed, 0);
`else
    check("p50_armed", armed, 0);
    cmd(OP_ACK, 1, 0, 0);
    timer = 70;
    ticks(8);
    check("p70_none", pending, 0);
`endif

    // Wrap-around on ch3
    timer = 64'hFFFF_FFFF_FFFF_FFF0;
    cmd(OP_ARM, 3, 64'd5, 0);
    ticks(8);
    check("wrap_hi", pending, 0);
    timer = 64'd4;
    ticks(8);
    check("wrap_4", pending, 0);
    timer = 64'd5;
    wait_pend(3, 4);
    check("wrap_pend",  pending, 4'b1000);
    check("wrap_armed", armed,   0);
    cmd(OP_ACK, 3, 0, 0);
    check("wrap_ack", pending, 0);

    // DISARM colliding with the scan visit that would fire ch0
    cmd(OP_ARM, 0, 200, 0);
    wait_scan(2'd0);
    timer = 200;
    cmd(OP_DISARM, 0, 0, 0);
    check("col_pend",  pending, 0);
    check("col_armed", armed,   0);
    ticks(8);
    check("col_later", pending, 0);

    // Clock enable hold with ch2 due
    cmd(OP_ARM, 2, 300, 0);
    wait_scan(2'd1);
    cke = 1'b0;
    timer = 300;
    #1;
    check("cke_ready", cfg_ready, 0);
    ticks(10);
    check("cke_scan", scan_ch, 1);
    check("cke_pend", pending, 0);
    cke = 1'b1;
    wait_pend(2, 4);
    check("cke_fire", pending, 4'b0100);

    // Asynchronous reset mid-operation
    arst_n = 1'b0;
    #1;
    check("mrst_pend",  pending,   0);
    check("mrst_irq",   irq,       0);
    check("mrst_ready", cfg_ready, 0);
    check("mrst_scan",  scan_ch,   0);
    tick();
    arst_n = 1'b1;
    for (int i = 1; i < N_CH; i++) begin
      tick();
      check("mrst_clear", cfg_ready, 0);
    end
    tick();
    check("mrst_ready1", cfg_ready, 1);
    check("mrst_armed",  armed,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
